// File: rtl/sequential_divider_ctrl.sv
// Restoring unsigned divider: one shared N+1-bit subtractor, one trial subtraction per cycle,
// wrapped in a START/BUSY/DONE handshake with registered results.

module N_BIT_SUBSTRACTOR #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] DIFF,
  output logic         BORROW_OUT
);
  assign {BORROW_OUT, DIFF} = {1'b0, A} - {1'b0, B};
endmodule

module sequential_divider_ctrl #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] DIVIDEND,
  input  logic [N-1:0] DIVISOR,
  output logic [N-1:0] QUOTIENT,
  output logic [N-1:0] REMAINDER,
  output logic         BUSY,
  output logic         DONE,
  output logic         DIV_BY_ZERO,
  output logic [1:0]   DBG_STATE
);
  // Handshake: START is taken on a rising edge whenever the block is not in CALC.
  // DONE pulses for one cycle with results valid; BUSY covers the N iteration edges.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    trial;
  logic [N:0]    diff;
  logic          borrow;
  logic          accept;
  logic          unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit is always zero.
  assign unused_r_msb = r_q[N];
  assign trial        = {r_q[N-1:0], q_q[N-1]};
  assign accept       = START && (state_q != CALC);

  N_BIT_SUBSTRACTOR #(.N(N + 1)) u_sub (
    .A          (trial),
    .B          ({1'b0, d_q}),
    .DIFF       (diff),
    .BORROW_OUT (borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      CALC: begin
        r_d = borrow ? trial : diff;
        q_d = {q_q[N-2:0], ~borrow};
        if (cnt_q == '0) begin
          state_d = FINISH;
          quot_d  = q_d;
          rem_d   = r_d[N-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (DIVISOR == '0) begin
            state_d = FINISH;
            quot_d  = '1;
            rem_d   = DIVIDEND;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            d_d     = DIVISOR;
            q_d     = DIVIDEND;
            r_d     = '0;
            cnt_d   = CW'(N - 1);
            dbz_d   = 1'b0;
          end
        end
      end
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rem_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign DIV_BY_ZERO = dbz_q;
  assign DBG_STATE   = state_q;
endmodule

// File: tb/tb_sequential_divider_ctrl.sv
// Bench for sequential_divider_ctrl (N=4): directed handshake cases plus all 256 operand pairs,
// results scored against a reference model through an expected queue.

module tb_sequential_divider_ctrl;
  localparam int N = 4;
  localparam int W = 2 * N + 1;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [N-1:0] DIVIDEND;
  logic [N-1:0] DIVISOR;
  logic [N-1:0] QUOTIENT;
  logic [N-1:0] REMAINDER;
  logic         BUSY;
  logic         DONE;
  logic         DIV_BY_ZERO;
  logic [1:0]   DBG_STATE;

  sequential_divider_ctrl #(.N(N)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .DBG_STATE   (DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  int           bs = 0, be = -1;
  logic         dbz_prev = 1'b0, dbz_new = 1'b0;
  int           dbz_at = 0;
  bit           mon_en = 1'b0;

  logic [W-1:0] mon_r;
  int           mon_t;
  logic         mon_busy, mon_dbz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] ref_div(input logic [N-1:0] dd, input logic [N-1:0] dv);
    if (dv == 0) return {1'b1, {N{1'b1}}, dd};
    return {1'b0, N'(dd / dv), N'(dd % dv)};
  endfunction

  function automatic logic cur_dbz(input int c);
    return (c >= dbz_at) ? dbz_new : dbz_prev;
  endfunction

  // driver: called at a falling edge, presents inputs for the next rising edge
  task automatic drive_cycle(input bit st, input logic [N-1:0] dd, input logic [N-1:0] dv,
                             output bit acc);
    int c;
    c        = cyc;
    START    = st;
    DIVIDEND = dd;
    DIVISOR  = dv;
    acc      = st && !(c >= bs && c <= be);
    if (acc) begin
      exp_q.push_back(ref_div(dd, dv));
      dbz_prev = cur_dbz(c);
      dbz_new  = (dv == 0);
      dbz_at   = c + 1;
      if (dv == 0) begin
        exp_t_q.push_back(c + 1);
      end else begin
        exp_t_q.push_back(c + 1 + N);
        bs = c + 1;
        be = c + N;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive_cycle(1'b0, '0, '0, acc);
  endtask

  task automatic divide(input logic [N-1:0] dd, input logic [N-1:0] dv);
    bit acc;
    int tries;
    tries = 0;
    do begin
      drive_cycle(1'b1, dd, dv, acc);
      tries++;
    end while (!acc && tries < 20);
    chk("start_accepted", 32'(acc), 32'd1);
  endtask

  // monitor: sampled at the falling edge
  always @(negedge CLK) begin
    if (mon_en) begin
      mon_busy = (cyc >= bs && cyc <= be);
      mon_dbz  = cur_dbz(cyc);
      chk("busy", 32'(BUSY), 32'(mon_busy));
      chk("dbz_flag", 32'(DIV_BY_ZERO), 32'(mon_dbz));
      if (DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_r = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          chk("result", 32'({DIV_BY_ZERO, QUOTIENT, REMAINDER}), 32'(mon_r));
          chk("latency", 32'(cyc), 32'(mon_t));
        end
      end else if (exp_t_q.size() > 0 && exp_t_q[0] <= cyc) begin
        chk("missing_done", 32'd0, 32'd1);
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    exp_t_q.delete();
    bs       = 0;
    be       = -1;
    dbz_prev = 1'b0;
    dbz_new  = 1'b0;
    dbz_at   = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_quotient"}, 32'(QUOTIENT), 32'd0);
    chk({tag, "_remainder"}, 32'(REMAINDER), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_dbz"}, 32'(DIV_BY_ZERO), 32'd0);
  endtask

  initial begin
    bit acc;
    int guard;
    RST_N    = 1'b1;
    START    = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    #3 RST_N = 1'b0;
    #1 check_zero_outputs("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // basic and boundary divisions
    divide(4'd13, 4'd3); idle(6);
    divide(4'd15, 4'd1); idle(6);
    divide(4'd2,  4'd7); idle(6);
    divide(4'd15, 4'd15); idle(6);

    // divide by zero, then a normal division clears the flag
    divide(4'd9, 4'd0); idle(3);
    divide(4'd6, 4'd2); idle(6);

    // START during CALC is ignored
    divide(4'd13, 4'd3);
    idle(1);
    drive_cycle(1'b1, 4'd8, 4'd2, acc);
    idle(6);

    // START held high: back-to-back divisions from FINISH
    for (int i = 0; i < 16; i++)
      drive_cycle(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), acc);
    idle(6);

    // asynchronous reset in the middle of an iteration
    divide(4'd13, 4'd3);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    clear_model();
    #1 check_zero_outputs("mid_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(1);
    divide(4'd7, 4'd2); idle(6);

    // every operand pair, with random gaps including none
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        divide(4'(dd), 4'(dv));
        idle($urandom_range(0, 2));
      end
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
